// File: rtl/boot_pkg.sv
// Shared types and constants for the serial image loader: frame field order,
// protocol and receiver state encodings, and the checksum helper.
package boot_pkg;

  // Position of each field within a frame, in arrival order.
  localparam int FIELD_SYNC   = 0;
  localparam int FIELD_ADDR_L = 1;
  localparam int FIELD_ADDR_H = 2;
  localparam int FIELD_LEN_L  = 3;
  localparam int FIELD_LEN_H  = 4;
  localparam int FIELD_DATA   = 5;
  localparam int FIELD_CSUM   = 6;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  // Protocol states are numbered after the field they are waiting for.
  typedef enum logic [2:0] {
    ST_SYNC   = 3'(FIELD_SYNC),
    ST_ADDR_L = 3'(FIELD_ADDR_L),
    ST_ADDR_H = 3'(FIELD_ADDR_H),
    ST_LEN_L  = 3'(FIELD_LEN_L),
    ST_LEN_H  = 3'(FIELD_LEN_H),
    ST_DATA   = 3'(FIELD_DATA),
    ST_CSUM   = 3'(FIELD_CSUM),
    ST_DONE   = 3'd7
  } boot_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Image checksum is the plain byte sum modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// RAM write port driven by the loader while the CPU is held in reset.
interface uart_boot_loader_if;
  // mem_we is a single-cycle strobe qualifying mem_addr/mem_data; there is no
  // ready, the RAM accepts a write in every cycle mem_we is high.
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;

  modport master (output mem_we, output mem_addr, output mem_data);
  modport slave  (input  mem_we, input  mem_addr, input  mem_data);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: 2-FF synchroniser, mid-bit sampling, start glitch
// rejection and stop bit check.
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int BIT_CNT = 347
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output rx_state_t  dbg_state
);

  localparam int CW = $clog2(BIT_CNT);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CNT - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     state;
  rx_state_t     state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          byte_valid_d;
  logic          frame_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_idx_d    = bit_idx;
    shift_d      = shift;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state)
      // IDLE is only entered with the line high, so a low here is a falling edge.
      RX_IDLE: begin
        if (!rx_sync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte   = shift;
  assign dbg_state = state;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial image loader: holds the CPU in reset, writes a framed image into RAM
// and releases the CPU once the image checksum matches.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         CLK_FREQ    = 40000000,
  parameter int         BAUD        = 115200,
  parameter int         TIMEOUT_CYC = 4000000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  uart_boot_loader_if.master       mem,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output boot_state_t              dbg_state,
  output rx_state_t                dbg_rx_state
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        frame_err;

  boot_state_t state;
  boot_state_t state_d;
  logic [15:0] addr;
  logic [15:0] addr_d;
  logic [15:0] len;
  logic [15:0] len_d;
  logic [7:0]  sum;
  logic [7:0]  sum_d;
  logic        error_q;
  logic        error_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  logic        wr_we;
  logic        wr_we_d;
  logic [15:0] wr_addr;
  logic [15:0] wr_addr_d;
  logic [7:0]  wr_data;
  logic [7:0]  wr_data_d;
  logic        in_frame;
  logic        timeout;

  uart_rx_byte #(.BIT_CNT(BIT_CNT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .dbg_state  (dbg_rx_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_SYNC;
      addr    <= '0;
      len     <= '0;
      sum     <= '0;
      error_q <= 1'b0;
      timer   <= '0;
      wr_we   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      len     <= len_d;
      sum     <= sum_d;
      error_q <= error_d;
      timer   <= timer_d;
      wr_we   <= wr_we_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

  assign in_frame = (state != ST_SYNC) && (state != ST_DONE);
  assign timeout  = in_frame && !byte_valid && (timer == TIMEOUT_LAST);

  always_comb begin
    state_d   = state;
    addr_d    = addr;
    len_d     = len;
    sum_d     = sum;
    error_d   = error_q;
    wr_we_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    // The idle timer only runs inside a frame and restarts on every byte.
    timer_d   = (!in_frame || byte_valid) ? '0 : timer + 1'b1;

    if (frame_err && state != ST_DONE) begin
      error_d = 1'b1;
      state_d = ST_SYNC;
    end else if (timeout) begin
      error_d = 1'b1;
      state_d = ST_SYNC;
    end else if (byte_valid) begin
      case (state)
        ST_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            state_d = ST_ADDR_L;
            sum_d   = '0;
          end
        end
        ST_ADDR_L: begin
          addr_d  = {addr[15:8], rx_byte};
          state_d = ST_ADDR_H;
        end
        ST_ADDR_H: begin
          addr_d  = {rx_byte, addr[7:0]};
          state_d = ST_LEN_L;
        end
        ST_LEN_L: begin
          len_d   = {len[15:8], rx_byte};
          state_d = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_d   = {rx_byte, len[7:0]};
          state_d = ({rx_byte, len[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          wr_we_d   = 1'b1;
          wr_addr_d = addr;
          wr_data_d = rx_byte;
          sum_d     = csum_add(sum, rx_byte);
          addr_d    = addr + 16'd1;
          len_d     = len - 16'd1;
          if (len == 16'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_byte == sum) begin
            state_d = ST_DONE;
          end else begin
            error_d = 1'b1;
            state_d = ST_SYNC;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  assign mem.mem_we   = wr_we;
  assign mem.mem_addr = wr_addr;
  assign mem.mem_data = wr_data;
  assign cpu_hold     = (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign busy         = in_frame;
  assign error        = error_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serial driver, frame-level reference model,
// write scoreboard and final report.
module tb_uart_boot_loader;
  import boot_pkg::*;

  localparam int CLK_FREQ    = 160000;
  localparam int BAUD        = 10000;
  localparam int BIT_CNT     = CLK_FREQ / BAUD;
  localparam int TIMEOUT_CYC = 2000;
  localparam int FERR        = 256;   // stream token: byte sent with a low stop bit

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  boot_state_t dbg_state;
  rx_state_t   dbg_rx_state;

  int tests_run = 0;
  int fails = 0;
  logic [23:0] exp_q[$];   // {addr, data} of each expected RAM write

  uart_boot_loader_if mem_if ();

  uart_boot_loader #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (8'h55)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .mem          (mem_if),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (4) tick();
    exp_q.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT_CNT) tick();
  endtask

  task automatic send_byte(input int v);
    logic [7:0] b;
    b = v[7:0];
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(v != FERR);
    if (v == FERR) bit_out(1'b1);
  endtask

  task automatic glitch(input int cycles);
    rx = 1'b0;
    repeat (cycles) tick();
    rx = 1'b1;
    repeat (2 * BIT_CNT) tick();
  endtask

  // reference model: parses the whole byte stream since reset at frame level
  task automatic model_run(input int s[$], input int from, input bit to_flag,
                           output bit ed, output bit ee, output bit eb);
    int v;
    int i;
    int len;
    int f[4];
    logic [15:0] a;
    logic [7:0] sum;
    bit cut;
    bit abort;
    ed = 0; ee = 0; eb = 0; i = 0; cut = 0;
    while (i < s.size() && !ed && !cut) begin
      v = s[i]; i++;
      if (v == FERR) ee = 1;
      else if (v == 'h55) begin
        abort = 0;
        for (int k = 0; k < 4 && !abort && !cut; k++) begin
          if (i >= s.size()) cut = 1;
          else begin
            v = s[i]; i++;
            if (v == FERR) begin ee = 1; abort = 1; end
            else f[k] = v;
          end
        end
        if (!abort && !cut) begin
          a = 16'(f[0] + 256 * f[1]);
          len = f[2] + 256 * f[3];
          sum = 8'd0;
          for (int k = 0; k < len && !abort && !cut; k++) begin
            if (i >= s.size()) cut = 1;
            else begin
              v = s[i]; i++;
              if (v == FERR) begin ee = 1; abort = 1; end
              else begin
                if (i - 1 >= from) exp_q.push_back({a, 8'(v)});
                a = a + 16'd1;
                sum = 8'((int'(sum) + v) % 256);
              end
            end
          end
        end
        if (!abort && !cut) begin
          if (i >= s.size()) cut = 1;
          else begin
            v = s[i]; i++;
            if (v == FERR) ee = 1;
            else if (8'(v) == sum) ed = 1;
            else ee = 1;
          end
        end
      end
    end
    if (cut) begin
      if (to_flag) ee = 1;
      else eb = 1;
    end
  endtask

  // sends s[from:] and checks status against the model of the full stream
  task automatic run_frame_test(input string name, input int s[$], input int from, input bit to_flag);
    bit ed, ee, eb;
    model_run(s, from, to_flag, ed, ee, eb);
    for (int k = from; k < s.size(); k++) begin
      send_byte(s[k]);
      repeat ($urandom_range(0, 12)) tick();
    end
    repeat (3 * BIT_CNT) tick();
    if (to_flag) repeat (TIMEOUT_CYC + 10) tick();
    check({name, "_done"}, done, ed);
    check({name, "_error"}, error, ee);
    check({name, "_busy"}, busy, eb);
    check({name, "_cpu_hold"}, cpu_hold, !ed);
    check({name, "_pending_writes"}, exp_q.size(), 0);
    if (!eb) check({name, "_state"}, dbg_state, ed ? ST_DONE : ST_SYNC);
  endtask

  // scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (!reset && mem_if.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 mem_if.mem_addr, mem_if.mem_data);
      end else begin
        check("mem_write", {mem_if.mem_addr, mem_if.mem_data}, exp_q.pop_front());
      end
    end
  end

  // stimulus
  initial begin
    int s[$];
    int fr[$];
    bit ed, ee, eb;
    logic [15:0] a;
    int len;
    int d;
    logic [7:0] sum;
    logic [7:0] cs;
    bit bad;

    // 1: reset state and idle line with start-bit glitches
    do_reset();
    check("rst_mem_we", mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_data", mem_if.mem_data, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_state", dbg_state, ST_SYNC);
    repeat (400) tick();
    glitch(3);
    glitch(5);
    repeat (1000) tick();
    check("idle_cpu_hold", cpu_hold, 1);
    check("idle_done", done, 0);
    check("idle_error", error, 0);
    check("idle_rx_state", dbg_rx_state, RX_IDLE);

    // 2: basic frame; model pinned against hand-computed writes
    do_reset();
    s = '{'h55, 'h00, 'h02, 'h03, 'h00, 'hAA, 'hBB, 'hCC, 'h31};
    model_run(s, 0, 0, ed, ee, eb);
    check("model_w0", exp_q[0], 24'h0200AA);
    check("model_w1", exp_q[1], 24'h0201BB);
    check("model_w2", exp_q[2], 24'h0202CC);
    check("model_done", ed, 1);
    exp_q.delete();
    run_frame_test("basic", s, 0, 0);
    check("basic_done_lit", done, 1);
    check("basic_hold_lit", cpu_hold, 0);

    // 3: bad checksum, then the correct frame without reset
    do_reset();
    s = '{'h55, 'h00, 'h02, 'h03, 'h00, 'hAA, 'hBB, 'hCC, 'h30};
    run_frame_test("bad_csum", s, 0, 0);
    check("bad_csum_error_lit", error, 1);
    fr = '{'h55, 'h00, 'h02, 'h03, 'h00, 'hAA, 'hBB, 'hCC, 'h31};
    foreach (fr[k]) s.push_back(fr[k]);
    run_frame_test("resend", s, 9, 0);

    // 4: address wrap
    do_reset();
    s = '{'h55, 'hFF, 'hFF, 'h02, 'h00, 'h11, 'h22, 'h33};
    model_run(s, 0, 0, ed, ee, eb);
    check("model_wrap_w1", exp_q[1], 24'h000022);
    exp_q.delete();
    run_frame_test("wrap", s, 0, 0);

    // 5: zero length, with and without leading junk
    do_reset();
    s = '{'h55, 'h00, 'h00, 'h00, 'h00, 'h00};
    run_frame_test("zero_len", s, 0, 0);
    do_reset();
    s = '{'h12, 'h55, 'h00, 'h00, 'h00, 'h00, 'h00};
    run_frame_test("junk_zero_len", s, 0, 0);

    // 6: timeout mid-header, then stop-bit fault mid-data
    do_reset();
    s = '{'h55, 'h00, 'h02};
    run_frame_test("partial", s, 0, 0);
    check("partial_busy_lit", busy, 1);
    run_frame_test("timeout", s, 3, 1);
    do_reset();
    s = '{'h55, 'h00, 'h03, 'h02, 'h00, 'hAA, FERR};
    run_frame_test("stop_low", s, 0, 0);

    // randomized frames
    for (int r = 0; r < 6; r++) begin
      do_reset();
      s.delete();
      fr.delete();
      if ($urandom_range(0, 1) == 1) s.push_back(int'($urandom_range(0, 'h54)));
      a = (r == 0) ? 16'hFFFE : 16'($urandom_range(0, 'hFFFF));
      len = $urandom_range(1, 5);
      fr.push_back('h55);
      fr.push_back(int'(a[7:0]));
      fr.push_back(int'(a[15:8]));
      fr.push_back(len);
      fr.push_back(0);
      sum = 8'd0;
      for (int k = 0; k < len; k++) begin
        d = $urandom_range(0, 255);
        fr.push_back(d);
        sum = sum + 8'(d);
      end
      bad = ($urandom_range(0, 2) == 0);
      cs = bad ? (sum ^ 8'($urandom_range(1, 255))) : sum;
      foreach (fr[k]) s.push_back(fr[k]);
      s.push_back(int'(cs));
      if (bad && $urandom_range(0, 1) == 1) begin
        foreach (fr[k]) s.push_back(fr[k]);
        s.push_back(int'(sum));
      end
      run_frame_test($sformatf("rand%0d", r), s, 0, 0);
    end

    // report
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
